mem_1r1w_fifo_ctrl: RTL and testbench
=====================================

Name: mem_1r1w_fifo_ctrl

Overview:
- Initiator-side controller for a mem_1r1w macro: owns both memory port groups and drives the addresses and strobes.
- Presents a valid/ready streaming FIFO to its clients: push side in, pop side out.
- Memory storage sits in the external macro; the controller holds pointers, occupancy and a 2-entry output skid buffer.
- Lets the regfile/queue designs use the hardened 1r1w macro as a show-ahead FIFO at full throughput.

Parameters:
- DEPTH_LOG2, 4, log2 of macro depth; ELEMENTS = 2**DEPTH_LOG2.
- WIDTH, 32, data width; must match the macro.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  push request.
- in_ready  out  1  push accept; combinational, = mem_count < ELEMENTS and resetn.
- in_data  in  WIDTH  push data.
- out_valid  out  1  head entry valid (output buffer non-empty).
- out_ready  in  1  pop accept.
- out_data  out  WIDTH  head entry.
- mem_read_addr  out  DEPTH_LOG2  to macro read_addr.
- mem_read  out  1  to macro read.
- mem_read_data  in  WIDTH  from macro read_data; valid exactly 1 cycle after mem_read=1.
- mem_write_addr  out  DEPTH_LOG2  to macro write_addr.
- mem_write  out  1  to macro write.
- mem_write_data  out  WIDTH  to macro write_data.
- level  out  DEPTH_LOG2+2  total entries held: mem_count + rd_inflight + out_count.

Behaviour:
- Reset (resetn=0 at a clk edge) has the following effects:
  - wr_ptr = rd_ptr = 0, mem_count = 0, rd_inflight = 0, out_count = 0, level = 0.
  - out_valid = 0 and out_data = 0.
  - mem_write and mem_read are forced 0 combinationally while resetn = 0.
- Reset mid-operation:
  - Discards all contents, including a read in flight.
  - The mem_read_data returned in the cycle after reset is ignored.
- Push (push = in_valid & in_ready):
  - Same cycle, combinationally: mem_write = 1, mem_write_addr = wr_ptr, mem_write_data = in_data.
  - wr_ptr increments at the edge and wraps ELEMENTS-1 -> 0.
- Read issue: mem_read = 1 in cycle t iff both conditions hold:
  - mem_count > 0, where mem_count is the registered value at the start of the cycle.
  - out_count + rd_inflight - pop_t <= 1, where pop_t = out_valid & out_ready.
- On read issue:
  - mem_read_addr = rd_ptr; rd_ptr increments and wraps.
  - rd_inflight <= 1 at the edge; otherwise rd_inflight <= 0.
- Land: when rd_inflight = 1, mem_read_data is written into the output buffer at the edge ending that cycle.
- Output buffer:
  - 2-entry FIFO; out_data is always the oldest entry.
  - Land and pop in the same cycle are both applied.
  - Capacity never exceeds 2, guaranteed by the issue rule.
- mem_count:
  - Increments by push and decrements by read issue.
  - Push and read issue in the same cycle leave it unchanged.
- Read/write address collision: mem_count uses the pre-push value, so the read address never equals the write address in the same cycle.
  - Reading a location requires mem_count > 0, so it is not the current wr_ptr.
  - When mem_count = ELEMENTS, pushes are blocked.
  - The controller therefore never relies on the macro's read-during-write behaviour.
- Latency: a push accepted in cycle t gives out_valid = 1 in cycle t+3 when the FIFO was empty.
  - Read issue in t+1.
  - Land at the end of t+2.
- Throughput: sustained 1 push and 1 pop per cycle once primed.
- Full: mem_count = ELEMENTS drives in_ready = 0; level can then reach ELEMENTS+2.
- Empty: out_valid = 0; popping with out_ready = 1 has no effect.
- Overflow and underflow of any counter are impossible by construction.
  - Assertions flag mem_count > ELEMENTS.
  - Assertions flag out_count > 2.

Test Plan:
- Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles with out_ready = 0 -> three mem_write pulses to addresses 0, 1, 2; out_valid rises 3 cycles after the first push; level reaches 3.
- Same FIFO, then assert out_ready -> out_data sequence A1, B2, C3 on consecutive cycles; out_valid falls after C3; level returns to 0.
- Hold out_ready = 0 and push until in_ready drops -> exactly 18 pushes accepted (16 in memory + 2 output buffer); level = 18; no mem_read issued while out_count = 2.
- Continuous push and pop for 40 cycles with data = cycle index -> output is an in-order gap-free sequence; write and read addresses wrap 15 -> 0; level is steady after priming.
- Random in_valid/out_ready at 50% for 2000 cycles against a scoreboard -> no loss, reorder or duplicate; mem_read_addr never equals mem_write_addr when both strobes are high.
- Assert resetn = 0 for 1 cycle while a read is in flight and the FIFO holds 5 entries -> next cycle out_valid = 0, level = 0, next push lands at address 0, and the stale mem_read_data never appears on out_data.

Source files
------------

// File: rtl/mem_1r1w_fifo_ctrl.sv
// Show-ahead FIFO controller driving an external 1r1w memory macro.
// Holds pointers, occupancy and a 2-entry output skid buffer.
module mem_1r1w_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2-1:0] mem_read_addr,
  output logic                  mem_read,
  input  logic [WIDTH-1:0]      mem_read_data,
  output logic [DEPTH_LOG2-1:0] mem_write_addr,
  output logic                  mem_write,
  output logic [WIDTH-1:0]      mem_write_data,
  output logic [DEPTH_LOG2+1:0] level
);

  localparam logic [DEPTH_LOG2:0] FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   mem_count_q, mem_count_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            out_count_q, out_count_d;
  logic [WIDTH-1:0]      buf0_q, buf0_d;
  logic [WIDTH-1:0]      buf1_q, buf1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] occ;
  logic [1:0] cnt_pop;

  assign in_ready  = resetn && (mem_count_q < FULL);
  assign push      = in_valid & in_ready;
  assign out_valid = (out_count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = buf0_q;

  // Skid slots that will be occupied after this cycle's pop; a new read
  // may only issue if a slot is guaranteed free when its data lands.
  assign occ   = out_count_q + {1'b0, rd_inflight_q} - {1'b0, pop};
  assign issue = resetn && (mem_count_q != '0) && (occ <= 2'd1);

  assign mem_write      = push;
  assign mem_write_addr = wr_ptr_q;
  assign mem_write_data = in_data;
  assign mem_read       = issue;
  assign mem_read_addr  = rd_ptr_q;

  assign level = {1'b0, mem_count_q}
               + {{(DEPTH_LOG2+1){1'b0}}, rd_inflight_q}
               + {{DEPTH_LOG2{1'b0}}, out_count_q};

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_count_d   = mem_count_q;
    rd_inflight_d = issue;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase
  end

  always_comb begin
    cnt_pop     = out_count_q - {1'b0, pop};
    buf0_d      = pop ? buf1_q : buf0_q;
    buf1_d      = buf1_q;
    out_count_d = cnt_pop;
    if (rd_inflight_q) begin
      if (cnt_pop == 2'd0) buf0_d = mem_read_data;
      else                 buf1_d = mem_read_data;
      out_count_d = cnt_pop + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      out_count_q   <= 2'd0;
      buf0_q        <= '0;
      buf1_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
      out_count_q   <= out_count_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (mem_count_q <= FULL);
      assert (out_count_q <= 2'd2);
    end
  end

endmodule

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
// Bench for mem_1r1w_fifo_ctrl: directed table, corner sequences and
// random traffic checked against a queue model plus a 1r1w macro model.
module tb_mem_1r1w_fifo_ctrl;

  localparam int DL = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [DL-1:0] mem_read_addr;
  logic          mem_read;
  logic [W-1:0]  mem_read_data = '0;
  logic [DL-1:0] mem_write_addr;
  logic          mem_write;
  logic [W-1:0]  mem_write_data;
  logic [DL+1:0] level;

  mem_1r1w_fifo_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_read_addr(mem_read_addr), .mem_read(mem_read),
    .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .level(level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Macro model: registered read data, one cycle after mem_read.
  logic [W-1:0] mem [2**DL];
  always @(posedge clk) begin
    if (mem_write && mem_read)
      chk("rw_collision", {124'b0, mem_read_addr == mem_write_addr}, 0);
    if (mem_write) mem[mem_write_addr] <= mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_read_addr];
  end

  // Reference model: FIFO contents as a queue.
  logic [W-1:0] q[$];
  int npop = 0;

  logic          r_ir, r_wr, r_rd, r_ov;
  logic [DL-1:0] r_wa, r_ra;
  logic [W-1:0]  r_od;
  logic [DL+1:0] r_lv;

  // Entered at posedge+1; drives one cycle and returns at next posedge+1.
  task automatic step(input logic iv, input logic [W-1:0] d,
                      input logic ordy);
    logic [W-1:0] e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    r_ir = in_ready; r_wr = mem_write; r_wa = mem_write_addr;
    r_rd = mem_read; r_ra = mem_read_addr; r_ov = out_valid;
    r_od = out_data; r_lv = level;
    chk("level_model", 128'(level), 128'(q.size()));
    if (out_valid && out_ready) begin
      npop++;
      if (q.size() == 0) chk("pop_empty", 1, 0);
      else begin
        e = q.pop_front();
        chk("pop_data", 128'(out_data), 128'(e));
      end
    end
    if (iv && in_ready) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q.delete();
  endtask

  typedef struct {
    logic iv; logic [W-1:0] d; logic ordy;
    logic ir; logic wr; logic [DL-1:0] wa;
    logic rd; logic [DL-1:0] ra;
    logic ov; logic [W-1:0] od; logic [DL+1:0] lv;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int acc, nrd, base, bad_lv;
    logic [127:0] act, exp;
    logic wwrap, rwrap;
    logic [DL-1:0] pwa, pra;

    tbl[0] = '{1, 32'hA1, 0, 1, 1, 0, 0, 0, 0, 0,     0};
    tbl[1] = '{1, 32'hB2, 0, 1, 1, 1, 1, 0, 0, 0,     1};
    tbl[2] = '{1, 32'hC3, 0, 1, 1, 2, 1, 1, 0, 0,     2};
    tbl[3] = '{0, 0,      0, 1, 0, 0, 0, 0, 1, 32'hA1, 3};
    tbl[4] = '{0, 0,      0, 1, 0, 0, 0, 0, 1, 32'hA1, 3};
    tbl[5] = '{0, 0,      1, 1, 0, 0, 1, 2, 1, 32'hA1, 3};
    tbl[6] = '{0, 0,      1, 1, 0, 0, 0, 0, 1, 32'hB2, 2};
    tbl[7] = '{0, 0,      1, 1, 0, 0, 0, 0, 1, 32'hC3, 1};
    tbl[8] = '{0, 0,      1, 1, 0, 0, 0, 0, 0, 0,     0};

    #1;
    do_reset();
    step(0, 0, 0);
    chk("reset_state", {r_ov, r_od, r_lv, r_rd, r_wr},
        {1'b0, 32'h0, 6'd0, 1'b0, 1'b0});

    // Directed fill and drain
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      act = {r_ir, r_wr, r_wr ? r_wa : 4'd0, r_rd, r_rd ? r_ra : 4'd0,
             r_ov, r_ov ? r_od : 32'd0, r_lv};
      exp = {tbl[i].ir, tbl[i].wr, tbl[i].wa, tbl[i].rd, tbl[i].ra,
             tbl[i].ov, tbl[i].od, tbl[i].lv};
      chk($sformatf("tbl_row%0d", i), act, exp);
    end

    // Fill to full with no pops
    do_reset();
    acc = 0; nrd = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, $urandom, 0);
      if (r_rd) nrd++;
      if (!r_ir) break;
      acc++;
    end
    chk("full_accepted", 128'(acc), 18);
    chk("full_level", 128'(r_lv), 18);
    chk("full_reads", 128'(nrd), 2);
    for (int i = 0; i < 25; i++) step(0, 0, 1);
    chk("full_drained", 128'(q.size()), 0);

    // Continuous streaming, wrap of both pointers
    do_reset();
    npop = 0; wwrap = 0; rwrap = 0; bad_lv = 0; base = 0;
    pwa = 0; pra = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, i, 1);
      if (r_wr) begin
        if (pwa == 4'd15 && r_wa == 4'd0) wwrap = 1;
        pwa = r_wa;
      end
      if (r_rd) begin
        if (pra == 4'd15 && r_ra == 4'd0) rwrap = 1;
        pra = r_ra;
      end
      if (i == 5) base = int'(r_lv);
      if (i > 5 && int'(r_lv) != base) bad_lv++;
    end
    chk("stream_level_steady", 128'(bad_lv), 0);
    chk("stream_primed_level", 128'(base), 3);
    chk("stream_wwrap", 128'(wwrap), 1);
    chk("stream_rwrap", 128'(rwrap), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    chk("stream_pops", 128'(npop), 40);

    // Random traffic
    do_reset();
    npop = 0;
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
    for (int i = 0; i < 30; i++) step(0, 0, 1);
    chk("rand_empty", {q.size() == 0, r_lv}, {1'b1, 6'd0});

    // Reset with a read in flight and 5 entries held
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h10 + i, 0);
    step(1, 32'h15, 1);
    chk("mid_issue", 128'(r_rd), 1);
    chk("mid_level", 128'(level), 5);
    resetn = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h99;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {in_ready, mem_write, mem_read}, 3'b000);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q.delete();
    npop = 0;
    step(1, 32'h55, 1);
    chk("post_rst_state", {r_ov, r_lv}, {1'b0, 6'd0});
    chk("post_rst_waddr", {r_wr, r_wa}, {1'b1, 4'd0});
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    chk("post_rst_pops", 128'(npop), 1);
    chk("post_rst_level", 128'(r_lv), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
